keypad_responder: RTL
=====================

# keypad_responder

Keypad responder for the safe design: the other end of the membrane keypad scan interface. It accepts 4-bit key codes from a host or test source into a small FIFO. It then emulates a 3-column × 4-row membrane keypad, asserting the matching row line whenever the scanner strobes the key's column. It holds each press for a programmable number of scans, then releases for a programmable gap. This lets the scanner and safe controller be driven with key sequences without a physical keypad.

## Interface
Parameters:
- HOLD_SCANS, 4: rising edges of the target column seen while pressed before release (1..15)
- GAP_SCANS, 4: rising edges of column 0 seen with no key pressed before the next press (1..15)
- FIFO_DEPTH, 4: key-code FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock
- rst  in  1  reset; asynchronous, active-high
- key_valid  in  1  host offers key_code
- key_code  in  4  key code = row*3 + col; valid range 0..11
- key_ready  out  1  FIFO not full
- col_in  in  3  column strobes from scanner, active-high
- row_out  out  4  row lines to scanner, active-high
- busy  out  1  FIFO non-empty or FSM not IDLE
- err  out  1  one-cycle pulse when an invalid code (12..15) is accepted

## Operation
- Handshake: a transfer occurs on a rising clk edge with key_valid && key_ready.
  - key_ready = !full, registered from the FIFO count.
  - Codes 12..15 are consumed but not stored; err pulses high the following cycle.
- col_in passes through a 2-flop synchronizer. A rising edge of synchronized bit k is a scan event for column k.
- FSM states: IDLE, PRESS, GAP.
  - IDLE: if the FIFO is non-empty, pop, latch row = code/3 and col = code%3, then go to PRESS.
  - PRESS: press_mask = one-hot(row). Count scan events on column col. At HOLD_SCANS, clear press_mask and go to GAP.
  - GAP: count scan events on column 0. At GAP_SCANS, go to IDLE.
- row_out = press_mask & {4{col_in[col]}}. This is combinational from the raw col_in, like a physical switch.
  - Multi-hot col_in still drives the row if col_in[col] is set.
  - Only column col's edges count toward HOLD_SCANS.
- Push and pop in the same cycle are allowed; the count is unchanged.
- If col_in never strobes the target column, the FSM stays in PRESS indefinitely. There is no timeout.

## Timing
- Reset (asynchronous) immediately forces:
  - row_out = 0, key_ready = 1, busy = 0, err = 0
  - FIFO empty, FSM IDLE, counters 0
- Reset mid-press releases the row in the same instant. Keys still queued are discarded.
- Accept at edge N: busy is high after edge N. FSM pops at edge N+1. press_mask is active after edge N+1.
- Scan-event latency: 3 clk edges from a col_in rise (2 synchronizer stages plus an edge-detect register).
- After the HOLD_SCANS-th event, press_mask clears on that same edge. row_out drops even if the column is still high.
- Back-to-back keys are always separated by GAP_SCANS column-0 events.
- FIFO full: key_ready low from the edge that made count = FIFO_DEPTH. A pop re-raises it one cycle later.
- Counters are 4 bits and saturate; they never wrap.

## Structure
- Shared package safe_pkg:
  - key-code constants: KEY_STAR = 9, KEY_0 = 10, KEY_HASH = 11, KEY_MAX = 11
  - NUM_ROWS = 4, NUM_COLS = 3
  - FSM state typedef (IDLE/PRESS/GAP)
- Sub-module key_fifo: synchronous FIFO with depth and width parameters, full/empty flags, registered count, same clk/rst.
- The top holds the synchronizer, edge detect, FSM, counters and row decode.

## Test plan
- Reset release with col_in cycling 001→010→100 and no keys → row_out stays 0, busy 0, key_ready 1.
- Push code 4 (row 1, col 1), HOLD_SCANS = 4 → row_out = 0010 only while col_in[1] = 1, for exactly 4 col1 strobes, then 0. busy drops after 4 further col0 strobes.
- Push 5 codes back-to-back with col_in static 000 → 4 accepted, key_ready low on the 5th. Strobing columns then drains the codes in order 4, 7, 0, 11.
- Push code 13 → not stored, err high one cycle, busy stays 0. A following code 2 is pressed as row 0, col 2 (row_out = 0001 when col_in[2]).
- Assert rst while row_out = 1000 with 2 keys queued → row_out 0 without a clock edge. After release, FIFO empty and no press occurs.
- Hold col_in = 111 during a press of code 1 → row_out = 0001. Only col1 edges advance the hold count.

Source files
------------

// File: rtl/safe_pkg.sv
// Shared constants, FSM state type and key decode
// helpers for the safe keypad blocks.
package safe_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  localparam logic [3:0] KEY_STAR = 4'd9;
  localparam logic [3:0] KEY_0    = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_MAX  = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP
  } key_state_t;

  // Row index of a key: code / 3 for codes 0..11.
  function automatic logic [1:0] key_row(
    input logic [3:0] code
  );
    if (code >= 4'd9)      key_row = 2'd3;
    else if (code >= 4'd6) key_row = 2'd2;
    else if (code >= 4'd3) key_row = 2'd1;
    else                   key_row = 2'd0;
  endfunction

  // One-hot row line driven while the key is down.
  function automatic logic [NUM_ROWS-1:0] row_mask(
    input logic [3:0] code
  );
    row_mask = 4'b0001 << key_row(code);
  endfunction

  // One-hot column whose strobe the key answers.
  function automatic logic [NUM_COLS-1:0] col_mask(
    input logic [3:0] code
  );
    logic [3:0] base;
    logic [3:0] c;
    base = {2'b00, key_row(code)} * 4'd3;
    c    = code - base;
    case (c)
      4'd0:    col_mask = 3'b001;
      4'd1:    col_mask = 3'b010;
      default: col_mask = 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO holding queued key codes.
// Count is registered; full/empty derive from it.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; push+pop keeps count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_responder.sv
// Emulated 3x4 membrane keypad: queued key codes
// are pressed against the scanner's column strobes.
module keypad_responder
  import safe_pkg::*;
#(
  parameter int HOLD_SCANS = 4,
  parameter int GAP_SCANS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic                key_ready,
  input  logic [NUM_COLS-1:0] col_in,
  output logic [NUM_ROWS-1:0] row_out,
  output logic                busy,
  output logic                err
);

  localparam logic [3:0] HOLD_N = 4'(HOLD_SCANS);
  localparam logic [3:0] GAP_N  = 4'(GAP_SCANS);

  logic                accept;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [3:0]          head;

  logic [NUM_COLS-1:0] s1;
  logic [NUM_COLS-1:0] s2;
  logic [NUM_COLS-1:0] s2d;
  logic [NUM_COLS-1:0] scan_ev;

  key_state_t          state_q, state_n;
  logic [3:0]          cnt_q, cnt_n;
  logic [3:0]          cnt_inc;
  logic [NUM_ROWS-1:0] mask_q, mask_n;
  logic [NUM_COLS-1:0] csel_q, csel_n;
  logic                err_q;

  assign key_ready = ~full;
  assign accept    = key_valid & key_ready;
  assign push      = accept & (key_code <= KEY_MAX);
  assign scan_ev   = s2 & ~s2d;
  assign cnt_inc   = (cnt_q == 4'hf) ? cnt_q
                                     : cnt_q + 4'd1;

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (key_code),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Column synchronizer plus edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= '0;
      s2  <= '0;
      s2d <= '0;
    end else begin
      s1  <= col_in;
      s2  <= s1;
      s2d <= s2;
    end
  end

  // Invalid codes are swallowed and flagged next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= accept & (key_code > KEY_MAX);
  end

  // Press FSM state, scan counter and latched key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      csel_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      mask_q  <= mask_n;
      csel_q  <= csel_n;
    end
  end

  // Next state: pop, hold for target scans, then gap.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    mask_n  = mask_q;
    csel_n  = csel_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          mask_n  = row_mask(head);
          csel_n  = col_mask(head);
          cnt_n   = '0;
          state_n = PRESS;
        end
      end
      PRESS: begin
        if (|(scan_ev & csel_q)) begin
          if (cnt_inc >= HOLD_N) begin
            mask_n  = '0;
            cnt_n   = '0;
            state_n = GAP;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      GAP: begin
        if (scan_ev[0]) begin
          if (cnt_inc >= GAP_N) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign row_out =
    mask_q & {NUM_ROWS{|(col_in & csel_q)}};
  assign busy    = ~empty | (state_q != IDLE);
  assign err     = err_q;

endmodule
